// File: rtl/flash_sample_scheduler.sv
// Paces flash-reader samples out at a fixed tick rate through a small prefetch FIFO,
// counting underruns and flagging end-of-stream.
module flash_sample_scheduler #(
    parameter int TICK_DIV    = 2268,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic        CLOCK_50,
    input  logic        resetb,
    input  logic        start,
    input  logic        pause,
    input  logic [15:0] rd_data,
    input  logic        rd_valid,
    input  logic        rd_done,
    output logic        rd_next,
    output logic [15:0] sample_out,
    output logic        sample_strobe,
    output logic        busy,
    output logic        finished,
    output logic [7:0]  underrun_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_PLAY, S_FINISHED} main_t;
    typedef enum logic [1:0] {F_WAIT, F_RELEASE, F_EXHAUSTED} fetch_t;

    main_t          state_q, state_d;
    fetch_t         fetch_q, fetch_d;
    logic [15:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    tick_q, tick_d;
    logic [15:0]    sample_q, sample_d;
    logic           strobe_q, strobe_d;
    logic [7:0]     under_q, under_d;
    logic           rd_next_q, busy_q, finished_q;
    logic           fetch_en, fifo_empty, fifo_full, exhausted, tick, push, pop;

    assign fetch_en   = (state_q == S_PRIME) || (state_q == S_PLAY);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign exhausted  = (fetch_q == F_EXHAUSTED);
    assign tick       = (state_q == S_PLAY) && !pause && (tick_q == 16'(TICK_DIV - 1));
    assign push       = fetch_en && (fetch_q == F_WAIT) && rd_valid && !fifo_full;
    assign pop        = tick && !fifo_empty;

    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            fetch_q <= F_WAIT;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PRIME;
            S_PRIME: if (count_q >= CW'(PRIME_LEVEL) || exhausted) state_d = S_PLAY;
            S_PLAY:  if (tick && fifo_empty && exhausted) state_d = S_FINISHED;
            default: state_d = state_q;
        endcase

        fetch_d = fetch_q;
        if (fetch_en) begin
            case (fetch_q)
                F_WAIT:    if (push) fetch_d = F_RELEASE;
                // rd_done wins over rd_valid so a reader that keeps valid high still terminates
                F_RELEASE: begin
                    if (rd_done)        fetch_d = F_EXHAUSTED;
                    else if (!rd_valid) fetch_d = F_WAIT;
                end
                default:   fetch_d = fetch_q;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        tick_d = tick_q;
        if (state_q == S_PRIME && state_d == S_PLAY) tick_d = '0;
        else if (state_q == S_PLAY && !pause)         tick_d = tick ? 16'd0 : tick_q + 16'd1;

        sample_d = pop ? mem_q[rptr_q] : sample_q;
        strobe_d = tick && !(fifo_empty && exhausted);

        under_d = under_q;
        if (tick && fifo_empty && !exhausted && under_q != 8'hFF) under_d = under_q + 8'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            tick_q     <= '0;
            sample_q   <= '0;
            strobe_q   <= 1'b0;
            under_q    <= '0;
            rd_next_q  <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q    <= count_d;
            tick_q     <= tick_d;
            sample_q   <= sample_d;
            strobe_q   <= strobe_d;
            under_q    <= under_d;
            // status flags follow next-state so they change on the same edge as the FSMs
            rd_next_q  <= (fetch_d == F_RELEASE);
            busy_q     <= (state_d == S_PRIME) || (state_d == S_PLAY);
            finished_q <= (state_d == S_FINISHED);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wptr_q] <= rd_data;
    end

    assign rd_next        = rd_next_q;
    assign sample_out     = sample_q;
    assign sample_strobe  = strobe_q;
    assign busy           = busy_q;
    assign finished       = finished_q;
    assign underrun_count = under_q;
endmodule

// File: tb/tb_flash_sample_scheduler.sv
// Bench for flash_sample_scheduler: reader model, strobe recorder and stream reference model.
module tb_flash_sample_scheduler;
  localparam int TDIV  = 32;
  localparam int DEPTH = 4;
  localparam int PRIME = 2;
  localparam int RUN_BOUND = 20000;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] rd_data = '0;
  logic        rd_valid = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_next, sample_strobe, busy, finished;
  logic [15:0] sample_out;
  logic [7:0]  underrun_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_sample_scheduler #(.TICK_DIV(TDIV), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .CLOCK_50(clk), .resetb(resetb), .start(start), .pause(pause),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done), .rd_next(rd_next),
    .sample_out(sample_out), .sample_strobe(sample_strobe), .busy(busy),
    .finished(finished), .underrun_count(underrun_count)
  );

  // Recorder: logs every strobe and counts release pulses; cleared while reset is low.
  int   cyc = 0;
  int   sv_q[$];
  int   uc_q[$];
  int   rises = 0, dbl = 0, last_strobe_cyc = 0, fin_cyc = -1;
  logic prev_next = 1'b0, prev_strobe = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!resetb) begin
      sv_q.delete();
      uc_q.delete();
      rises <= 0;
      dbl <= 0;
      last_strobe_cyc <= 0;
      fin_cyc <= -1;
      prev_next <= 1'b0;
      prev_strobe <= 1'b0;
    end else begin
      prev_next <= rd_next;
      prev_strobe <= sample_strobe;
      if (rd_next && !prev_next) rises <= rises + 1;
      if (sample_strobe) begin
        sv_q.push_back(int'(sample_out));
        uc_q.push_back(int'(underrun_count));
        last_strobe_cyc <= cyc;
        if (prev_strobe) dbl <= dbl + 1;
      end
      if (finished && fin_cyc < 0) fin_cyc <= cyc;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_next(input logic v);
    int k = 0;
    while (rd_next !== v && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 3000) chk("reader handshake timeout", int'(rd_next), int'(v));
  endtask

  // Reader: sample i carries value i+1; the last release raises rd_done with valid low,
  // or in race mode rd_done rises two cycles after the final valid while valid stays high.
  task automatic reader(input int n, input int lmin, input int lmax, input bit race);
    for (int i = 0; i < n; i++) begin
      int lat;
      lat = int'($urandom_range(lmax, lmin));
      repeat (lat) @(posedge clk);
      #1;
      rd_data = 16'(i + 1);
      rd_valid = 1'b1;
      if (race && i == n - 1) begin
        repeat (2) @(posedge clk);
        #1 rd_done = 1'b1;
      end else begin
        wait_next(1'b1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        if (i == n - 1) rd_done = 1'b1;
        wait_next(1'b0);
      end
    end
  endtask

  task automatic do_reset();
    #1;
    resetb = 1'b0; start = 1'b0; pause = 1'b0;
    rd_valid = 1'b0; rd_done = 1'b0; rd_data = '0;
    repeat (3) @(posedge clk);
    #1 resetb = 1'b1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " rd_next"}, int'(rd_next), 0);
    chk({nm, " sample_out"}, int'(sample_out), 0);
    chk({nm, " sample_strobe"}, int'(sample_strobe), 0);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " finished"}, int'(finished), 0);
    chk({nm, " underrun_count"}, int'(underrun_count), 0);
  endtask

  task automatic pulse_start(input string nm);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({nm, " busy after start"}, int'(busy), 1);
  endtask

  // Reference model: each strobe is either the next sample in order or a repeat of the
  // last one (an underrun); the underrun counter tracks repeats, saturating at 255.
  task automatic check_stream(input string nm, input int n);
    int nxt = 1;
    int rep = 0;
    for (int i = 0; i < sv_q.size(); i++) begin
      checks++;
      if (sv_q[i] == nxt) nxt++;
      else if (nxt > 1 && sv_q[i] == nxt - 1) rep++;
      else begin
        errors++;
        $display("FAIL %s strobe %0d value: got %0d expected %0d", nm, i, sv_q[i], nxt);
      end
      chk({nm, " underrun_count at strobe"}, uc_q[i], (rep > 255) ? 255 : rep);
    end
    chk({nm, " samples played"}, nxt - 1, n);
  endtask

  task automatic finish_checks(input string nm, input int n, input int exp_uc);
    int k = 0;
    while (!finished && k < RUN_BOUND) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " finished reached"}, int'(finished), 1);
    disable fork;
    repeat (2) @(posedge clk); #1;
    check_stream(nm, n);
    chk({nm, " captures"}, rises, n);
    chk({nm, " strobe wider than 1"}, dbl, 0);
    chk({nm, " finish delay"}, fin_cyc - last_strobe_cyc, TDIV);
    chk({nm, " rd_next after finish"}, int'(rd_next), 0);
    chk({nm, " busy after finish"}, int'(busy), 0);
    if (exp_uc >= 0) chk({nm, " underrun total"}, int'(underrun_count), exp_uc);
    start = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk({nm, " finished holds"}, int'(finished), 1);
    chk({nm, " start ignored"}, int'(busy), 0);
    start = 1'b0;
  endtask

  typedef struct {
    string nm;
    int    n;
    int    lmin;
    int    lmax;
    bit    race;
    int    exp_uc;   // -1: not predicted, only the per-strobe model applies
  } scen_t;

  scen_t tbl[4];

  initial begin
    int k;
    tbl[0] = '{nm: "normal",   n: 256, lmin: 20,  lmax: 20,  race: 1'b0, exp_uc: 0};
    tbl[1] = '{nm: "random",   n: 64,  lmin: 0,   lmax: 40,  race: 1'b0, exp_uc: -1};
    tbl[2] = '{nm: "donerace", n: 40,  lmin: 30,  lmax: 30,  race: 1'b1, exp_uc: -1};
    tbl[3] = '{nm: "saturate", n: 140, lmin: 100, lmax: 100, race: 1'b0, exp_uc: 255};

    for (int s = 0; s < 4; s++) begin
      do_reset();
      chk_reset_outs({tbl[s].nm, " reset"});
      fork
        reader(tbl[s].n, tbl[s].lmin, tbl[s].lmax, tbl[s].race);
      join_none
      pulse_start(tbl[s].nm);
      finish_checks(tbl[s].nm, tbl[s].n, tbl[s].exp_uc);
    end

    // Backpressure: paused playback, FIFO fills and the reader is held off.
    do_reset();
    pause = 1'b1;
    fork
      reader(8, 0, 0, 1'b0);
    join_none
    pulse_start("bp");
    repeat (200) @(posedge clk); #1;
    chk("bp captures while paused", rises, DEPTH);
    chk("bp rd_next while full", int'(rd_next), 0);
    chk("bp strobes while paused", sv_q.size(), 0);
    chk("bp busy", int'(busy), 1);
    pause = 1'b0;
    k = 0;
    while (!sample_strobe && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp first strobe delay", k, TDIV);
    chk("bp first value", int'(sample_out), 1);
    finish_checks("bp", 8, 0);

    // Reset in the middle of playback, then a fresh run.
    do_reset();
    fork
      reader(50, 5, 5, 1'b0);
    join_none
    pulse_start("midrst");
    repeat (300) @(posedge clk); #1;
    chk("midrst busy before", int'(busy), 1);
    chk("midrst sample nonzero", int'(sample_out != 16'd0), 1);
    resetb = 1'b0;
    #1;
    chk_reset_outs("midrst async");
    disable fork;
    rd_valid = 1'b0; rd_done = 1'b0;
    @(posedge clk); #1 resetb = 1'b1;
    chk("midrst idle after reset", int'(busy), 0);
    fork
      reader(20, 3, 8, 1'b0);
    join_none
    pulse_start("restart");
    finish_checks("restart", 20, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
